// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths match the core's integer register file.
package regfile_sb_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  // The hardwired zero register.
  localparam logic [DefAddrW-1:0] RegZero = '0;

  typedef logic [DefDataW-1:0] word_t;
  typedef logic [DefAddrW-1:0] reg_addr_t;

  // True when an access targets the hardwired zero register and must be suppressed.
  function automatic logic is_zero_reg(input logic zero_reg_en, input reg_addr_t addr);
    return zero_reg_en && (addr == RegZero);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, write and reserve signals between the issue/writeback logic and the register file.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_valid, busy_cnt
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, rd_valid, busy_cnt
  );

endinterface

// File: rtl/regfile_sb_busy.sv
// Per-register busy scoreboard with a running count of busy registers.
// Reserve beats writeback-clear on the same register (the reserving instruction is newer).
module regfile_sb_busy
  import regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic                  rsv_en_i,
  input  logic [ADDR_W-1:0]     rsv_addr_i,
  output logic [2**ADDR_W-1:0]  busy_o,
  output logic [2**ADDR_W-1:0]  busy_next_o,
  output logic [ADDR_W:0]       busy_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntOne = 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wr_eff, rsv_eff, inc, dec;

  assign wr_eff  = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i == '0));
  assign rsv_eff = rsv_en_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));

  always_comb begin
    busy_d = busy_q;
    if (wr_eff)  busy_d[wr_addr_i]  = 1'b0;
    if (rsv_eff) busy_d[rsv_addr_i] = 1'b1;
  end

  // Count moves by at most one: a same-address write+reserve can only ever increment.
  always_comb begin
    inc   = rsv_eff && !busy_q[rsv_addr_i];
    dec   = wr_eff && busy_q[wr_addr_i] && !(rsv_eff && (rsv_addr_i == wr_addr_i));
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign busy_next_o = busy_d;
  assign busy_cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with registered reads, optional write bypass,
// optional hardwired zero register and a busy scoreboard for RAW hazard detection.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic         clk,
  input  logic         clear,
  regfile_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_next;
  logic [ADDR_W:0]   busy_cnt;

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic              rd_busy_a_q, rd_busy_a_d, rd_busy_b_q, rd_busy_b_d;
  logic              rd_valid_q;
  logic              wr_eff, zero_a, zero_b, hit_a, hit_b;

  regfile_sb_busy #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk         (clk),
    .clear       (clear),
    .wr_en_i     (bus.wr_en),
    .wr_addr_i   (bus.wr_addr),
    .rsv_en_i    (bus.rsv_en),
    .rsv_addr_i  (bus.rsv_addr),
    .busy_o      (busy_q),
    .busy_next_o (busy_next),
    .busy_cnt_o  (busy_cnt)
  );

  assign wr_eff = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign zero_a = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
  assign zero_b = (ZERO_REG != 0) && (bus.rd_addr_b == '0);
  assign hit_a  = (BYPASS != 0) && wr_eff && (bus.wr_addr == bus.rd_addr_a);
  assign hit_b  = (BYPASS != 0) && wr_eff && (bus.wr_addr == bus.rd_addr_b);

  // With bypass the read sees post-edge state (data and busy); without, pre-edge state.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_busy_a_d = rd_busy_a_q;
    rd_busy_b_d = rd_busy_b_q;
    if (bus.rd_en) begin
      rd_data_a_d = zero_a ? '0 : (hit_a ? bus.wr_data : mem_q[bus.rd_addr_a]);
      rd_data_b_d = zero_b ? '0 : (hit_b ? bus.wr_data : mem_q[bus.rd_addr_b]);
      if (BYPASS != 0) begin
        rd_busy_a_d = !zero_a && busy_next[bus.rd_addr_a];
        rd_busy_b_d = !zero_b && busy_next[bus.rd_addr_b];
      end else begin
        rd_busy_a_d = !zero_a && busy_q[bus.rd_addr_a];
        rd_busy_b_d = !zero_b && busy_q[bus.rd_addr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_busy_a_q <= 1'b0;
      rd_busy_b_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      if (wr_eff) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_busy_a_q <= rd_busy_a_d;
      rd_busy_b_q <= rd_busy_b_d;
      rd_valid_q  <= bus.rd_en;
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.rd_busy_a = rd_busy_a_q;
  assign bus.rd_busy_b = rd_busy_b_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy_cnt  = busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared every cycle against an array model, plus hand-computed spot values.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  logic      rd_en, wr_en, rsv_en;
  reg_addr_t ra, rb, wa, rsa;
  word_t     wd;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b1 ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b0 ();

  assign bus_b1.rd_en = rd_en;   assign bus_b0.rd_en = rd_en;
  assign bus_b1.rd_addr_a = ra;  assign bus_b0.rd_addr_a = ra;
  assign bus_b1.rd_addr_b = rb;  assign bus_b0.rd_addr_b = rb;
  assign bus_b1.wr_en = wr_en;   assign bus_b0.wr_en = wr_en;
  assign bus_b1.wr_addr = wa;    assign bus_b0.wr_addr = wa;
  assign bus_b1.wr_data = wd;    assign bus_b0.wr_data = wd;
  assign bus_b1.rsv_en = rsv_en; assign bus_b0.rsv_en = rsv_en;
  assign bus_b1.rsv_addr = rsa;  assign bus_b0.rsv_addr = rsa;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_b1 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_b1)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b0 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_b0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model state: architectural contents, and expected outputs for both instances.
  word_t m_mem  [NREG];
  logic  m_busy [NREG];
  word_t e1_a, e1_b, e0_a, e0_b;
  logic  e1_ba, e1_bb, e0_ba, e0_bb, e_valid;
  int    e_cnt;
  bit    model_ok = 1'b0;

  // Called with this cycle's inputs applied, before the edge that consumes them.
  task automatic model_update();
    word_t old_mem  [NREG];
    logic  old_busy [NREG];
    if (clear) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      e1_a = '0; e1_b = '0; e0_a = '0; e0_b = '0;
      e1_ba = 0; e1_bb = 0; e0_ba = 0; e0_bb = 0;
      e_valid = 0;
      e_cnt = 0;
      model_ok = 1'b1;
    end else begin
      old_mem  = m_mem;
      old_busy = m_busy;
      if (wr_en && wa != 0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rsv_en && rsa != 0) m_busy[rsa] = 1'b1;
      e_valid = rd_en;
      if (rd_en) begin
        e1_a = m_mem[ra];    e1_ba = m_busy[ra];
        e1_b = m_mem[rb];    e1_bb = m_busy[rb];
        e0_a = old_mem[ra];  e0_ba = old_busy[ra];
        e0_b = old_mem[rb];  e0_bb = old_busy[rb];
      end
      e_cnt = 0;
      for (int i = 0; i < NREG; i++) e_cnt += int'(m_busy[i]);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("cmp_b1_valid",  32'(bus_b1.rd_valid),  32'(e_valid));
      chk("cmp_b1_cnt",    32'(bus_b1.busy_cnt),  32'(e_cnt));
      chk("cmp_b1_data_a", bus_b1.rd_data_a,      e1_a);
      chk("cmp_b1_data_b", bus_b1.rd_data_b,      e1_b);
      chk("cmp_b1_busy_a", 32'(bus_b1.rd_busy_a), 32'(e1_ba));
      chk("cmp_b1_busy_b", 32'(bus_b1.rd_busy_b), 32'(e1_bb));
      chk("cmp_b0_valid",  32'(bus_b0.rd_valid),  32'(e_valid));
      chk("cmp_b0_cnt",    32'(bus_b0.busy_cnt),  32'(e_cnt));
      chk("cmp_b0_data_a", bus_b0.rd_data_a,      e0_a);
      chk("cmp_b0_data_b", bus_b0.rd_data_b,      e0_b);
      chk("cmp_b0_busy_a", 32'(bus_b0.rd_busy_a), 32'(e0_ba));
      chk("cmp_b0_busy_b", 32'(bus_b0.rd_busy_b), 32'(e0_bb));
    end
  end

  task automatic idle();
    rd_en = 0; wr_en = 0; rsv_en = 0;
    ra = '0; rb = '0; wa = '0; rsa = '0; wd = '0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    clear = 1'b1;
    step();
    step();
    chk("rst_cnt", 32'(bus_b1.busy_cnt), 32'd0);
    chk("rst_valid", 32'(bus_b1.rd_valid), 32'd0);
    clear = 1'b0;

    // 1: write r0 (ignored) and r5, then read both
    wr_en = 1; wa = 0; wd = 32'h123ABC01; step();
    wa = 5; wd = 32'hAAAABCAA; step();
    idle(); rd_en = 1; ra = 0; rb = 5; step();
    chk("t1_valid", 32'(bus_b1.rd_valid), 32'd1);
    chk("t1_a_r0", bus_b1.rd_data_a, 32'h0);
    chk("t1_b_r5", bus_b1.rd_data_b, 32'hAAAABCAA);
    chk("t1_b_r5_nobyp", bus_b0.rd_data_b, 32'hAAAABCAA);
    chk("t1_busy", {bus_b1.rd_busy_a, bus_b1.rd_busy_b}, 32'd0);
    idle(); step();
    chk("t1_valid_drop", 32'(bus_b1.rd_valid), 32'd0);
    chk("t1_hold", bus_b1.rd_data_b, 32'hAAAABCAA);

    // 2: same-cycle write and read of r7
    wr_en = 1; wa = 7; wd = 32'hDEADBEEF; rd_en = 1; ra = 7; rb = 5; step();
    chk("t2_bypass", bus_b1.rd_data_a, 32'hDEADBEEF);
    chk("t2_nobypass", bus_b0.rd_data_a, 32'h0);

    // 3: reserve r3, r4; read; write r3; read again
    idle(); rsv_en = 1; rsa = 3; step();
    chk("t3_cnt1", 32'(bus_b1.busy_cnt), 32'd1);
    rsa = 4; step();
    chk("t3_cnt2", 32'(bus_b1.busy_cnt), 32'd2);
    idle(); rd_en = 1; ra = 3; rb = 4; step();
    chk("t3_busy_r3", 32'(bus_b1.rd_busy_a), 32'd1);
    idle(); wr_en = 1; wa = 3; wd = 32'h00000033; step();
    chk("t3_cnt_after_wr", 32'(bus_b1.busy_cnt), 32'd1);
    idle(); rd_en = 1; ra = 3; rb = 3; step();
    chk("t3_busy_r3_clr", 32'(bus_b1.rd_busy_a), 32'd0);
    chk("t3_data_r3", bus_b1.rd_data_a, 32'h00000033);

    // 4: reserve+write r9 together; then reserve r10 while writing busy r4
    idle(); wr_en = 1; wa = 9; wd = 32'h99990009; rsv_en = 1; rsa = 9; step();
    chk("t4_cnt_r9", 32'(bus_b1.busy_cnt), 32'd2);
    idle(); rd_en = 1; ra = 9; rb = 9; step();
    chk("t4_data_r9", bus_b1.rd_data_a, 32'h99990009);
    chk("t4_busy_r9", 32'(bus_b1.rd_busy_a), 32'd1);
    idle(); rsv_en = 1; rsa = 10; wr_en = 1; wa = 4; wd = 32'h00000044;
    rd_en = 1; ra = 10; rb = 4; step();
    chk("t4_cnt_net0", 32'(bus_b1.busy_cnt), 32'd2);
    chk("t4_byp_rsv_busy", 32'(bus_b1.rd_busy_a), 32'd1);
    chk("t4_nobyp_rsv_busy", 32'(bus_b0.rd_busy_a), 32'd0);
    chk("t4_byp_wr_busy", 32'(bus_b1.rd_busy_b), 32'd0);
    chk("t4_nobyp_wr_busy", 32'(bus_b0.rd_busy_b), 32'd1);

    // 5: r0 never goes busy or takes data; fill the scoreboard
    idle(); rsv_en = 1; rsa = 0; step();
    chk("t5_rsv_r0", 32'(bus_b1.busy_cnt), 32'd2);
    idle(); wr_en = 1; wa = 0; wd = 32'hFFFFFFFF; step();
    idle(); rd_en = 1; ra = 0; rb = 0; step();
    chk("t5_r0_data", bus_b1.rd_data_a, 32'h0);
    chk("t5_r0_busy", 32'(bus_b1.rd_busy_a), 32'd0);
    idle(); rsv_en = 1;
    for (int i = 1; i < NREG; i++) begin
      rsa = reg_addr_t'(i);
      step();
    end
    chk("t5_cnt_full", 32'(bus_b1.busy_cnt), 32'd31);
    rsa = 31; step();
    chk("t5_cnt_sat", 32'(bus_b0.busy_cnt), 32'd31);

    // 6: clear while a read, write and reserve are all requested
    idle(); wr_en = 1; wa = 12; wd = 32'h12121212; rsv_en = 1; rsa = 13;
    rd_en = 1; ra = 9; rb = 5; clear = 1'b1; step();
    chk("t6_valid", 32'(bus_b1.rd_valid), 32'd0);
    chk("t6_data_a", bus_b1.rd_data_a, 32'h0);
    chk("t6_cnt", 32'(bus_b1.busy_cnt), 32'd0);
    clear = 1'b0;
    idle(); rd_en = 1;
    for (int i = 0; i < NREG; i++) begin
      ra = reg_addr_t'(i);
      rb = reg_addr_t'(NREG - 1 - i);
      step();
    end
    chk("t6_r31_data", bus_b1.rd_data_a, 32'h0);
    chk("t6_r0_after", bus_b0.rd_data_b, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
